// File: rtl/matrix_scan_bcm_pkg.sv
// Shared types and width helpers for the HUB75 binary-coded-modulation scanner.
package matrix_scan_bcm_pkg;

    typedef enum logic [1:0] {
        SHIFT   = 2'd0,
        BLANK   = 2'd1,
        LATCH   = 2'd2,
        DISPLAY = 2'd3
    } scan_state_t;

    // Counter width able to index n distinct values, never narrower than one bit.
    function automatic int bits_for(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // The display interval peaks at 2^DIM_BITS << (DEPTH-1), so this width never overflows.
    function automatic int timer_bits(input int dim_bits, input int depth);
        return dim_bits + depth;
    endfunction

endpackage

// File: rtl/matrix_scan_bcm_bcm_timer.sv
// Loadable down-counter timing the DISPLAY interval of one bit-plane.
module matrix_scan_bcm_bcm_timer #(
    parameter int WIDTH = 10
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    output logic             running
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = value;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign running = (count_q != '0);

endmodule

// File: rtl/matrix_scan_bcm.sv
// HUB75 matrix scanner: shifts a row out, latches it, then lights it for a
// bit-plane on-time of (dim+1) << plane cycles.
module matrix_scan_bcm
    import matrix_scan_bcm_pkg::*;
#(
    parameter  int COLUMNS  = 64,
    parameter  int ROW_BITS = 4,
    parameter  int DEPTH    = 6,
    parameter  int DIM_BITS = 4,
    localparam int COL_BITS = bits_for(COLUMNS)
) (
    input  logic                clk_in,
    input  logic                reset,
    input  logic [DIM_BITS-1:0] dim,
    output logic [COL_BITS-1:0] column_address,
    output logic [ROW_BITS-1:0] row_address,
    output logic [DEPTH-1:0]    brightness_mask,
    output logic                clk_pixel,
    output logic                row_latch,
    output logic                output_enable,
    output logic                frame_done
);

    localparam int PLANE_BITS = bits_for(DEPTH);
    localparam int TIMER_BITS = timer_bits(DIM_BITS, DEPTH);

    scan_state_t         state_q, state_d;
    logic [COL_BITS-1:0] col_q, col_d;
    logic                phase_q, phase_d;
    logic [ROW_BITS-1:0] row_q, row_d;
    logic [ROW_BITS-1:0] row_addr_q, row_addr_d;
    logic [PLANE_BITS-1:0] plane_q, plane_d;
    logic [DEPTH-1:0]    mask_q, mask_d;
    logic [DIM_BITS-1:0] dim_q, dim_d;
    logic                latch_q, latch_d;
    logic                oe_q, oe_d;
    logic                frame_done_q, frame_done_d;

    logic                  timer_load;
    logic                  timer_running;
    logic [TIMER_BITS-1:0] timer_value;

    assign timer_value = (TIMER_BITS'(dim_q) + TIMER_BITS'(1)) << plane_q;

    matrix_scan_bcm_bcm_timer #(
        .WIDTH (TIMER_BITS)
    ) u_bcm_timer (
        .clk_in  (clk_in),
        .reset   (reset),
        .load    (timer_load),
        .value   (timer_value),
        .running (timer_running)
    );

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        phase_d      = phase_q;
        row_d        = row_q;
        row_addr_d   = row_addr_q;
        plane_d      = plane_q;
        mask_d       = mask_q;
        dim_d        = dim_q;
        frame_done_d = 1'b0;
        timer_load   = 1'b0;

        unique case (state_q)
            SHIFT: begin
                if (!phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    if (col_q == COL_BITS'(COLUMNS - 1)) begin
                        col_d   = '0;
                        state_d = BLANK;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            BLANK: begin
                // Timer loaded here so it reaches zero on the last DISPLAY cycle.
                timer_load = 1'b1;
                row_addr_d = row_q;
                state_d    = LATCH;
            end
            LATCH: begin
                state_d = DISPLAY;
            end
            DISPLAY: begin
                if (!timer_running) begin
                    state_d = SHIFT;
                    if (plane_q == PLANE_BITS'(DEPTH - 1)) begin
                        plane_d = '0;
                        if (row_q == '1) begin
                            row_d        = '0;
                            frame_done_d = 1'b1;
                            dim_d        = dim;
                        end else begin
                            row_d = row_q + 1'b1;
                        end
                    end else begin
                        plane_d = plane_q + 1'b1;
                    end
                    mask_d = DEPTH'(1) << plane_d;
                end
            end
            default: begin
                state_d = SHIFT;
            end
        endcase

        latch_d = (state_d == LATCH);
        oe_d    = (state_d == DISPLAY);
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q      <= SHIFT;
            col_q        <= '0;
            phase_q      <= 1'b0;
            row_q        <= '0;
            row_addr_q   <= '0;
            plane_q      <= '0;
            mask_q       <= DEPTH'(1);
            latch_q      <= 1'b0;
            oe_q         <= 1'b0;
            frame_done_q <= 1'b0;
            // NOTE: dim_q takes the live dim input during reset so the first frame uses it.
            dim_q        <= dim;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            phase_q      <= phase_d;
            row_q        <= row_d;
            row_addr_q   <= row_addr_d;
            plane_q      <= plane_d;
            mask_q       <= mask_d;
            latch_q      <= latch_d;
            oe_q         <= oe_d;
            frame_done_q <= frame_done_d;
            dim_q        <= dim_d;
        end
    end

    assign column_address  = col_q;
    assign row_address     = row_addr_q;
    assign brightness_mask = mask_q;
    assign clk_pixel       = phase_q;
    assign row_latch       = latch_q;
    assign output_enable   = oe_q;
    assign frame_done      = frame_done_q;

endmodule
